// File: rtl/mips_pkg.sv
// Shared MIPS core constants: datapath defaults, load-type encodings and
// the hard-wired zero register index.
package mips_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;

    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LW  = 3'b010;
    localparam logic [2:0] LT_LBU = 3'b100;
    localparam logic [2:0] LT_LHU = 3'b101;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Unsigned loads zero-extend; every other code sign-extends or is a word.
    function automatic logic lt_is_unsigned(input logic [2:0] lt);
        return (lt == LT_LBU) || (lt == LT_LHU);
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM -> WB bundle: pipeline control and memory-stage results in, register
// file write port and forwarding tap out.
interface mem_wb_stage_if
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) ();

    logic              stall;
    logic              flush;
    logic              in_valid;
    logic              in_regwrite;
    logic              in_memtoreg;
    logic              in_link;
    logic [2:0]        in_load_type;
    logic [1:0]        in_addr_lo;
    logic [DATA_W-1:0] in_alu_result;
    logic [DATA_W-1:0] in_mem_rdata;
    logic [DATA_W-1:0] in_pc_plus4;
    logic [REG_AW-1:0] in_write_reg;

    logic              regwrite;
    logic [REG_AW-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic              fwd_valid;
    logic [REG_AW-1:0] fwd_reg;
    logic [DATA_W-1:0] fwd_data;
    logic              misalign_err;

    // Upstream pipeline side
    modport master (
        output stall, flush, in_valid, in_regwrite, in_memtoreg, in_link,
               in_load_type, in_addr_lo, in_alu_result, in_mem_rdata,
               in_pc_plus4, in_write_reg,
        input  regwrite, write_reg, write_data, fwd_valid, fwd_reg, fwd_data,
               misalign_err
    );

    // Writeback stage side
    modport slave (
        input  stall, flush, in_valid, in_regwrite, in_memtoreg, in_link,
               in_load_type, in_addr_lo, in_alu_result, in_mem_rdata,
               in_pc_plus4, in_write_reg,
        output regwrite, write_reg, write_data, fwd_valid, fwd_reg, fwd_data,
               misalign_err
    );

endinterface

// File: rtl/mem_wb_stage_load_extract.sv
// Big-endian load extraction: picks the byte/halfword addressed by addr_lo
// out of an aligned memory word, extends it, and flags misaligned accesses.
module load_extract
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        addr_lo,
    input  logic [2:0]        load_type,
    output logic [DATA_W-1:0] data,
    output logic              misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        uns;

    // Lane select, extension and alignment check
    always_comb begin
        byte_sel   = '0;
        half_sel   = '0;
        data       = rdata;
        misaligned = 1'b0;
        uns        = lt_is_unsigned(load_type);

        // addr_lo = 0 is the most significant byte
        case (addr_lo)
            2'd0:    byte_sel = rdata[DATA_W-1 -: 8];
            2'd1:    byte_sel = rdata[DATA_W-9 -: 8];
            2'd2:    byte_sel = rdata[15:8];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr_lo[1] ? rdata[15:0] : rdata[DATA_W-1 -: 16];

        case (load_type)
            LT_LB, LT_LBU: begin
                data = uns ? {{(DATA_W-8){1'b0}}, byte_sel}
                           : {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            end
            LT_LH, LT_LHU: begin
                data       = uns ? {{(DATA_W-16){1'b0}}, half_sel}
                                 : {{(DATA_W-16){half_sel[15]}}, half_sel};
                misaligned = addr_lo[0];
            end
            // LW and every unassigned code pass the word through
            default: begin
                data       = rdata;
                misaligned = (addr_lo != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback select. Each captured entry writes
// the register file at most once even if the stage is held by a stall; the
// forwarding tap stays live for the whole time the entry is held.
// Optional: define WB_RETIRE_CNT_EN to add the retire_cnt output.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    mem_wb_stage_if.slave    bus
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0]      retire_cnt
`endif
);

    logic              valid;
    logic              written;
    logic              r_regwrite;
    logic              r_memtoreg;
    logic              r_link;
    logic [2:0]        r_load_type;
    logic [1:0]        r_addr_lo;
    logic [DATA_W-1:0] r_alu;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_pc4;
    logic [REG_AW-1:0] r_wreg;

    logic [DATA_W-1:0] ld_data;
    logic              lx_mis;
    logic              mis;
    logic              wr_ok;
    logic [DATA_W-1:0] wb_data;

    // Stage register: flush beats stall; a stalled entry marks itself written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid       <= 1'b0;
            written     <= 1'b0;
            r_regwrite  <= 1'b0;
            r_memtoreg  <= 1'b0;
            r_link      <= 1'b0;
            r_load_type <= '0;
            r_addr_lo   <= '0;
            r_alu       <= '0;
            r_rdata     <= '0;
            r_pc4       <= '0;
            r_wreg      <= '0;
        end else if (bus.flush) begin
            valid <= 1'b0;
        end else if (bus.stall) begin
            if (valid)
                written <= 1'b1;
        end else begin
            valid       <= bus.in_valid;
            written     <= 1'b0;
            r_regwrite  <= bus.in_regwrite;
            r_memtoreg  <= bus.in_memtoreg;
            r_link      <= bus.in_link;
            r_load_type <= bus.in_load_type;
            r_addr_lo   <= bus.in_addr_lo;
            r_alu       <= bus.in_alu_result;
            r_rdata     <= bus.in_mem_rdata;
            r_pc4       <= bus.in_pc_plus4;
            r_wreg      <= bus.in_write_reg;
        end
    end

    load_extract #(.DATA_W(DATA_W)) u_lx (
        .rdata      (r_rdata),
        .addr_lo    (r_addr_lo),
        .load_type  (r_load_type),
        .data       (ld_data),
        .misaligned (lx_mis)
    );

    // Misalignment only matters when the load data is actually consumed
    assign mis   = r_memtoreg & lx_mis;
    assign wr_ok = valid & r_regwrite & (r_wreg != REG_AW'(REG_ZERO));

    // Writeback source: link beats load beats ALU
    always_comb begin
        wb_data = r_alu;
        if (r_link)
            wb_data = r_pc4;
        else if (r_memtoreg)
            wb_data = ld_data;
    end

    assign bus.regwrite     = wr_ok & ~mis & ~written;
    assign bus.write_reg    = r_wreg;
    assign bus.write_data   = wb_data;
    assign bus.fwd_valid    = wr_ok & ~mis;
    assign bus.fwd_reg      = r_wreg;
    assign bus.fwd_data     = wb_data;
    assign bus.misalign_err = wr_ok & mis & ~written;

`ifdef WB_RETIRE_CNT_EN
    // Count each entry once, in its first cycle, unless it was misaligned
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            retire_cnt <= '0;
        else if (valid & ~written & ~mis)
            retire_cnt <= retire_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with a behavioural reference model and a
// per-cycle compare process; literal checks pin the model's expectations.
module tb_mem_wb_stage;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_wb_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    mem_wb_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_cnt (retire_cnt)
`endif
    );

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        rw;
        logic        mtr;
        logic        link;
        logic [2:0]  lt;
        logic [1:0]  a;
        logic [31:0] alu;
        logic [31:0] rd;
        logic [31:0] pc;
        logic [4:0]  wr;
    } ent_t;

    ent_t        m_e;
    bit          m_valid;
    bit          m_written;
    logic [31:0] m_ret;

    function automatic logic [31:0] f_load(input logic [31:0] w, input int a, input int lt);
        logic [31:0] b, h;
        b = (w >> ((3 - a) * 8)) & 32'hFF;
        h = (a >= 2) ? (w & 32'hFFFF) : (w >> 16);
        case (lt)
            0: return (b >= 32'h80) ? (b + 32'hFFFF_FF00) : b;
            4: return b;
            1: return (h >= 32'h8000) ? (h + 32'hFFFF_0000) : h;
            5: return h;
            default: return w;
        endcase
    endfunction

    function automatic bit f_mis(input int lt, input int a);
        if (lt == 1 || lt == 5) return (a % 2) == 1;
        if (lt == 0 || lt == 4) return 1'b0;
        return a != 0;
    endfunction

    function automatic bit m_is_mis();
        return m_e.mtr && f_mis(int'(m_e.lt), int'(m_e.a));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid   = 1'b0;
            m_written = 1'b0;
            m_e       = '0;
            m_ret     = '0;
        end else begin
            if (m_valid && !m_written && !m_is_mis()) m_ret = m_ret + 1;
            if (bus.flush) begin
                m_valid = 1'b0;
            end else if (bus.stall) begin
                if (m_valid) m_written = 1'b1;
            end else begin
                m_e.rw    = bus.in_regwrite;
                m_e.mtr   = bus.in_memtoreg;
                m_e.link  = bus.in_link;
                m_e.lt    = bus.in_load_type;
                m_e.a     = bus.in_addr_lo;
                m_e.alu   = bus.in_alu_result;
                m_e.rd    = bus.in_mem_rdata;
                m_e.pc    = bus.in_pc_plus4;
                m_e.wr    = bus.in_write_reg;
                m_valid   = bus.in_valid;
                m_written = 1'b0;
            end
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        logic [31:0] d;
        bit          mis;
        bit          live;
        mis  = m_is_mis();
        d    = m_e.link ? m_e.pc : (m_e.mtr ? f_load(m_e.rd, int'(m_e.a), int'(m_e.lt)) : m_e.alu);
        live = m_valid && m_e.rw && (m_e.wr != 0);
        chk("cmp_regwrite",  {31'd0, bus.regwrite},     {31'd0, live && !mis && !m_written});
        chk("cmp_misalign",  {31'd0, bus.misalign_err}, {31'd0, live && mis && !m_written});
        chk("cmp_fwd_valid", {31'd0, bus.fwd_valid},    {31'd0, live && !mis});
        chk("cmp_write_reg", {27'd0, bus.write_reg},    {27'd0, m_e.wr});
        chk("cmp_fwd_reg",   {27'd0, bus.fwd_reg},      {27'd0, m_e.wr});
        chk("cmp_write_data", bus.write_data, d);
        chk("cmp_fwd_data",   bus.fwd_data,   d);
`ifdef WB_RETIRE_CNT_EN
        chk("cmp_retire_cnt", retire_cnt, m_ret);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic set_in(input bit v, input bit rw, input bit mtr, input bit link,
                          input logic [2:0] lt, input logic [1:0] a,
                          input logic [31:0] alu, input logic [31:0] rd,
                          input logic [31:0] pc, input logic [4:0] wr);
        bus.in_valid      = v;
        bus.in_regwrite   = rw;
        bus.in_memtoreg   = mtr;
        bus.in_link       = link;
        bus.in_load_type  = lt;
        bus.in_addr_lo    = a;
        bus.in_alu_result = alu;
        bus.in_mem_rdata  = rd;
        bus.in_pc_plus4   = pc;
        bus.in_write_reg  = wr;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 3'd0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] RD = 32'h80FF_7F01;

    initial begin
        int pulses;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        tick();
        chk("reset_regwrite", {31'd0, bus.regwrite}, 32'd0);
        chk("reset_write_data", bus.write_data, 32'd0);

        // Reset in the middle of a live entry
        set_in(1, 1, 0, 0, LT_LW, 2'd0, 32'hDEAD_BEEF, 32'd0, 32'd0, 5'd5);
        tick();
        chk("pre_rst_regwrite", {31'd0, bus.regwrite}, 32'd1);
        idle();
        #1 rst = 1'b1;
        #1;
        chk("rst_regwrite",  {31'd0, bus.regwrite},  32'd0);
        chk("rst_fwd_valid", {31'd0, bus.fwd_valid}, 32'd0);
        chk("rst_write_reg", {27'd0, bus.write_reg}, 32'd0);
        chk("rst_write_data", bus.write_data, 32'd0);
        #1 rst = 1'b0;
        tick();
        chk("post_rst_regwrite", {31'd0, bus.regwrite}, 32'd0);

        // ALU writeback
        set_in(1, 1, 0, 0, LT_LW, 2'd0, 32'h0000_00A5, 32'd0, 32'd0, 5'd8);
        tick();
        chk("alu_regwrite", {31'd0, bus.regwrite}, 32'd1);
        chk("alu_write_reg", {27'd0, bus.write_reg}, 32'd8);
        chk("alu_write_data", bus.write_data, 32'h0000_00A5);
        idle();
        tick();
        chk("alu_next_regwrite", {31'd0, bus.regwrite}, 32'd0);

        // Loads
        set_in(1, 1, 1, 0, LT_LB, 2'd0, 32'h11, RD, 32'd0, 5'd9);
        tick();
        chk("lb0", bus.write_data, 32'hFFFF_FF80);
        set_in(1, 1, 1, 0, LT_LBU, 2'd1, 32'h11, RD, 32'd0, 5'd9);
        tick();
        chk("lbu1", bus.write_data, 32'h0000_00FF);
        set_in(1, 1, 1, 0, LT_LH, 2'd2, 32'h11, RD, 32'd0, 5'd9);
        tick();
        chk("lh2", bus.write_data, 32'h0000_7F01);
        set_in(1, 1, 1, 0, LT_LW, 2'd1, 32'h11, RD, 32'd0, 5'd9);
        tick();
        chk("lw1_misalign", {31'd0, bus.misalign_err}, 32'd1);
        chk("lw1_regwrite", {31'd0, bus.regwrite}, 32'd0);
        idle();
        tick();
        chk("lw1_misalign_end", {31'd0, bus.misalign_err}, 32'd0);

        // Sweep every load code and offset; the compare process checks each
        for (int lt = 0; lt < 8; lt++) begin
            for (int a = 0; a < 4; a++) begin
                set_in(1, 1, 1, 0, 3'(lt), 2'(a), 32'h55, 32'h9C3E_A217, 32'd0,
                       5'(1 + (lt * 4 + a) % 31));
                tick();
            end
        end

        // Register $0 and link
        set_in(1, 1, 0, 0, LT_LW, 2'd0, 32'h77, 32'd0, 32'd0, 5'd0);
        tick();
        chk("r0_regwrite",  {31'd0, bus.regwrite},  32'd0);
        chk("r0_fwd_valid", {31'd0, bus.fwd_valid}, 32'd0);
        set_in(1, 1, 0, 1, LT_LW, 2'd0, 32'h99, 32'd0, 32'h0040_0010, 5'd31);
        tick();
        chk("link_write_data", bus.write_data, 32'h0040_0010);
        chk("link_write_reg", {27'd0, bus.write_reg}, 32'd31);

        // Stall for three cycles: one write, tap live throughout
        set_in(1, 1, 0, 0, LT_LW, 2'd0, 32'h1234, 32'd0, 32'd0, 5'd10);
        tick();
        bus.stall = 1'b1;
        set_in(1, 1, 0, 0, LT_LW, 2'd0, 32'h0BAD, 32'd0, 32'd0, 5'd11);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            pulses += int'(bus.regwrite);
            chk("stall_fwd_valid", {31'd0, bus.fwd_valid}, 32'd1);
            chk("stall_fwd_data", bus.fwd_data, 32'h1234);
            if (i == 2) begin
                bus.stall = 1'b0;
                idle();
            end
            tick();
        end
        chk("stall_pulses", 32'(pulses), 32'd1);

        // Flush together with stall kills the entry
        set_in(1, 1, 0, 0, LT_LW, 2'd0, 32'h42, 32'd0, 32'd0, 5'd12);
        tick();
        chk("pre_flush_fwd", {31'd0, bus.fwd_valid}, 32'd1);
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        tick();
        chk("flush_fwd_valid", {31'd0, bus.fwd_valid}, 32'd0);
        chk("flush_regwrite",  {31'd0, bus.regwrite},  32'd0);
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        idle();
        tick();

`ifdef WB_RETIRE_CNT_EN
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        chk("retire_reset", retire_cnt, 32'd0);
        set_in(1, 1, 1, 0, LT_LW, 2'd0, 32'h1, RD, 32'd0, 5'd3);
        tick();
        set_in(1, 1, 0, 0, LT_LW, 2'd0, 32'h2, RD, 32'd0, 5'd4);
        tick();
        set_in(1, 1, 1, 0, LT_LW, 2'd2, 32'h3, RD, 32'd0, 5'd5);
        tick();
        set_in(1, 1, 1, 0, LT_LB, 2'd1, 32'h4, RD, 32'd0, 5'd6);
        tick();
        set_in(1, 1, 0, 0, LT_LW, 2'd0, 32'h5, RD, 32'd0, 5'd7);
        tick();
        idle();
        tick();
        chk("retire_cnt_4", retire_cnt, 32'd4);
`endif

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
